alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the combinational 64-bit datapath ALU. Accepts one operation per cycle over a valid/ready input, registers the result plus NZCV-style flags, and presents them over a valid/ready output. Single-cycle ops have 1-cycle latency; an optional iterative multiplier takes WIDTH cycles. Sits between the register-read stage and writeback, and supplies `zero` for branch resolution.

## Interface
- `WIDTH`, 64, operand/result width; power of two, ≥ 8
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block can accept this cycle
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B (shift amount in b[$clog2(WIDTH)-1:0])
- `alu_ctrl`  in  4  opcode
- `out_valid`  out  1  result register holds an unconsumed result
- `out_ready`  in  1  consumer takes result this cycle
- `z`  out  WIDTH  result
- `zero`  out  1  z == 0
- `neg`  out  1  z[WIDTH-1]
- `carry`  out  1  carry / no-borrow
- `ovf`  out  1  signed overflow
- `err`  out  1  illegal opcode (or MUL when compiled out)

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a−b), 0111 PASS_B, 0011 XOR, 0100 LSL a by b, 0101 LSR a by b, 1000 MUL (low WIDTH bits of a*b, unsigned). All others illegal.
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- ADD: carry = carry-out of bit WIDTH-1; ovf = operands same sign, result sign differs.
- SUB: computed as a + ~b + 1; carry = 1 when a ≥ b unsigned (no borrow); ovf = operand signs differ and result sign ≠ a sign.
- AND/OR/XOR/PASS_B/LSL/LSR/MUL: carry = 0, ovf = 0. Shift by 0 returns a.
- zero and neg always derived from the registered z. All flags update together with z.
- Illegal opcode: z = 0, zero = 1, carry = ovf = neg = 0, err = 1; still completes with 1-cycle latency. err = 0 for every legal op.
- FSM: IDLE, BUSY.
  - IDLE: in_ready = !out_valid || out_ready. Accepting a single-cycle op writes the output register; accepting MUL loads multiplicand, multiplier, accumulator = 0, count = WIDTH, goes BUSY; if out_ready is high in the same cycle, out_valid falls on that edge.
  - BUSY: in_ready = 0; in_valid ignored. Each edge processes one multiplier bit (shift-add) and decrements count. The edge on which count goes 1→0 writes z/flags, sets out_valid, returns IDLE.
- Output register holds z and all flags stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release internally not required): out_valid = 0, z = 0, zero = 0, neg = 0, carry = 0, ovf = 0, err = 0, state = IDLE, count = 0. in_ready = 1 after reset.
- Reset asserted mid-MUL aborts the operation; no result is produced.
- Single-cycle op accepted at edge N: out_valid high after edge N; back-to-back throughput 1 op/cycle while out_ready = 1.
- MUL accepted at edge N: out_valid high after edge N+WIDTH; in_ready low for cycles N+1 … N+WIDTH.
- Output stalled (out_valid=1, out_ready=0): in_ready = 0, nothing accepted, no overwrite.

## Configuration
- `ALU_MUL_EN` defined: iterative multiplier, counter, and BUSY state compiled in; MUL behaves as above.
- Undefined: no multiplier logic; 1000 treated as illegal opcode (z = 0, err = 1, 1-cycle latency); in_ready never drops for MUL reasons.

## Test plan
- WIDTH=64, ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> next cycle out_valid=1, z=0, zero=1, carry=1, ovf=0, neg=0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> z=0x8000_0000_0000_0000, ovf=1, neg=1, carry=0; SUB a=5, b=7 -> z=0xFFFF_FFFF_FFFF_FFFE, neg=1, carry=0.
- Back-to-back AND, OR, LSL(a=1,b=63), LSR(a=0x8000…0,b=63) with out_ready=1 -> four results on consecutive cycles: correct values, last two 0x8000…0 and 1.
- Hold out_ready=0 for 5 cycles after an ADD -> z/flags unchanged, in_ready=0; raise out_ready -> transfer, in_ready=1 same cycle.
- With `ALU_MUL_EN`: MUL a=3, b=5 -> in_ready low 64 cycles, out_valid after edge N+64, z=15; assert rst_n=0 at cycle 20 of a second MUL -> out_valid=0, in_ready=1, no result. Without macro: MUL -> z=0, err=1 next cycle.
- Opcode 1111 -> z=0, zero=1, err=1; following legal ADD clears err.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and NZCV-style flags.
// Single-cycle ops complete one edge after acceptance. Define ALU_MUL_EN to
// compile in the iterative shift-add multiplier (opcode 1000, WIDTH cycles);
// without it opcode 1000 is reported as illegal.
module alu_pipe #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    localparam int unsigned SH = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_LSL  = 4'b0100,
        OP_LSR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_PASS = 4'b0111,
        OP_MUL  = 4'b1000
    } op_e;

    logic             accept;
    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_z;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic             wr_en;
    logic [WIDTH-1:0] wr_z;
    logic             wr_carry;
    logic             wr_ovf;
    logic             wr_err;

    assign accept = in_valid && in_ready;

    // ADD and SUB share one adder: SUB is a + ~b + 1
    assign sub_op = (alu_ctrl == OP_SUB);
    assign b_eff  = sub_op ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};

    // Single-cycle result and flags for the presented opcode
    always_comb begin
        alu_z     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_z = a & b;
            OP_OR:   alu_z = a | b;
            OP_XOR:  alu_z = a ^ b;
            OP_PASS: alu_z = b;
            OP_LSL:  alu_z = a << b[SH-1:0];
            OP_LSR:  alu_z = a >> b[SH-1:0];
            OP_ADD, OP_SUB: begin
                alu_z     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, BUSY} state_e;
    localparam int unsigned CW = SH + 1;

    state_e           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_z;

    assign is_mul   = (alu_ctrl == OP_MUL);
    assign mul_done = (state == BUSY) && (count == CW'(1));
    assign mul_z    = acc + (mplier[0] ? mcand : '0);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);

    // Select what the output register captures: finished product or ALU result
    always_comb begin
        wr_en    = accept && !is_mul;
        wr_z     = alu_z;
        wr_carry = alu_carry;
        wr_ovf   = alu_ovf;
        wr_err   = alu_err;
        if (mul_done) begin
            wr_en    = 1'b1;
            wr_z     = mul_z;
            wr_carry = 1'b0;
            wr_ovf   = 1'b0;
            wr_err   = 1'b0;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    // Output register captures the ALU result on every accepted op
    always_comb begin
        wr_en    = accept;
        wr_z     = alu_z;
        wr_carry = alu_carry;
        wr_ovf   = alu_ovf;
        wr_err   = alu_err;
    end
`endif

    // Output register, valid flag and multiplier FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_MUL_EN
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
`endif
        end else begin
            if (wr_en) begin
                out_valid <= 1'b1;
                z         <= wr_z;
                zero      <= (wr_z == '0);
                neg       <= wr_z[WIDTH-1];
                carry     <= wr_carry;
                ovf       <= wr_ovf;
                err       <= wr_err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MUL_EN
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= mul_z;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=64) against
// an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, XOR_ = 4'b0011;
    localparam logic [3:0] LSL_ = 4'b0100, LSR_ = 4'b0101, SUB_ = 4'b0110, PASS_ = 4'b0111;
    localparam logic [3:0] MUL_ = 4'b1000, BAD_ = 4'b1111;
    localparam logic signed [127:0] SMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] SMIN = -128'sh8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0] z;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
        logic        err;
    } res_t;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] a, b, z;
    logic [3:0]  alu_ctrl;
    logic        zero, neg, carry, ovf, err;
    res_t        obs;
    int          passed, total;

    assign obs = {z, zero, neg, carry, ovf, err};

    alu_pipe #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural reference: result computed from the arithmetic meaning of each opcode
    function automatic res_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        res_t r;
        logic [127:0] w;
        logic signed [127:0] sx, sy, sr;
        r  = '0;
        sx = {{64{x[63]}}, x};
        sy = {{64{y[63]}}, y};
        case (op)
            AND_:  r.z = x & y;
            OR_:   r.z = x | y;
            XOR_:  r.z = x ^ y;
            PASS_: r.z = y;
            LSL_:  r.z = x << y[5:0];
            LSR_:  r.z = x >> y[5:0];
            ADD_: begin
                w = {64'h0, x} + {64'h0, y};
                r.z = w[63:0];
                r.carry = (w[127:64] != 0);
                sr = sx + sy;
                r.ovf = (sr > SMAX) || (sr < SMIN);
            end
            SUB_: begin
                r.z = x - y;
                r.carry = (x >= y);
                sr = sx - sy;
                r.ovf = (sr > SMAX) || (sr < SMIN);
            end
`ifdef ALU_MUL_EN
            MUL_: begin
                w = {64'h0, x} * {64'h0, y};
                r.z = w[63:0];
            end
`endif
            default: r.err = 1'b1;
        endcase
        r.zero = (r.z == 64'h0);
        r.neg  = r.z[63];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        in_valid = v;
        alu_ctrl = op;
        a = x;
        b = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, AND_, 64'h0, 64'h0);
        out_ready = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
        total++;
        if (obs !== res_t'(0)) $display("FAIL reset_result: got %h want 0", obs);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_sub();
        res_t exp;
        out_ready = 1'b1;
        drive(1'b1, ADD_, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        step();
        in_valid = 1'b0;
        exp = res_t'{z: 64'h0, zero: 1'b1, neg: 1'b0, carry: 1'b1, ovf: 1'b0, err: 1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== exp) $display("FAIL add_wrap: got v=%b %h want v=1 %h", out_valid, obs, exp);
        else passed++;
        drive(1'b1, ADD_, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        step();
        in_valid = 1'b0;
        exp = res_t'{z: 64'h8000_0000_0000_0000, zero: 1'b0, neg: 1'b1, carry: 1'b0, ovf: 1'b1, err: 1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== exp) $display("FAIL add_ovf: got v=%b %h want v=1 %h", out_valid, obs, exp);
        else passed++;
        drive(1'b1, SUB_, 64'd5, 64'd7);
        step();
        in_valid = 1'b0;
        exp = res_t'{z: 64'hFFFF_FFFF_FFFF_FFFE, zero: 1'b0, neg: 1'b1, carry: 1'b0, ovf: 1'b0, err: 1'b0};
        total++;
        if (out_valid !== 1'b1 || obs !== exp) $display("FAIL sub_borrow: got v=%b %h want v=1 %h", out_valid, obs, exp);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [63:0] xs [4];
        logic [63:0] ys [4];
        res_t exp;
        ops = '{AND_, OR_, LSL_, LSR_};
        xs  = '{{$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'h1, 64'h8000_0000_0000_0000};
        ys  = '{{$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'd63, 64'd63};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], xs[i], ys[i]);
            #1;
            total++;
            if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
            else passed++;
            step();
            exp = model(ops[i], xs[i], ys[i]);
            total++;
            if (out_valid !== 1'b1 || obs !== exp) $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", i, out_valid, obs, exp);
            else passed++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        res_t exp;
        logic [63:0] x, y;
        x = {$urandom(), $urandom()};
        y = {$urandom(), $urandom()};
        out_ready = 1'b0;
        drive(1'b1, ADD_, x, y);
        step();
        exp = model(ADD_, x, y);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, XOR_, {$urandom(), $urandom()}, {$urandom(), $urandom()});
            #1;
            total++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready);
            else passed++;
            total++;
            if (out_valid !== 1'b1 || obs !== exp) $display("FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", k, out_valid, obs, exp);
            else passed++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready);
        else passed++;
        step();
        total++;
        if (out_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_illegal();
        res_t exp;
        logic [63:0] x, y;
        out_ready = 1'b1;
        drive(1'b1, BAD_, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        step();
        exp = res_t'{z: 64'h0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b1};
        total++;
        if (out_valid !== 1'b1 || obs !== exp) $display("FAIL illegal_op: got v=%b %h want v=1 %h", out_valid, obs, exp);
        else passed++;
        x = {$urandom(), $urandom()};
        y = {$urandom(), $urandom()};
        drive(1'b1, ADD_, x, y);
        step();
        in_valid = 1'b0;
        exp = model(ADD_, x, y);
        total++;
        if (out_valid !== 1'b1 || obs !== exp) $display("FAIL illegal_then_add: got v=%b %h want v=1 %h", out_valid, obs, exp);
        else passed++;
        step();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        res_t exp;
        logic [63:0] xs [2];
        logic [63:0] ys [2];
        int bad;
        xs = '{64'd3, {$urandom(), $urandom()}};
        ys = '{64'd5, {$urandom(), $urandom()}};
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, MUL_, xs[t], ys[t]);
            step();
            drive(1'b1, ADD_, 64'h1, 64'h1);
            bad = 0;
            for (int k = 1; k <= 64; k++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
                step();
            end
            in_valid = 1'b0;
            total++;
            if (bad != 0) $display("FAIL mul_busy[%0d]: got %0d bad cycles want 0", t, bad);
            else passed++;
            exp = (t == 0) ? res_t'{z: 64'd15, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b0}
                           : model(MUL_, xs[t], ys[t]);
            total++;
            if (out_valid !== 1'b1 || obs !== exp) $display("FAIL mul_result[%0d]: got v=%b %h want v=1 %h", t, out_valid, obs, exp);
            else passed++;
            step();
        end
        drive(1'b1, MUL_, 64'd7, 64'd9);
        step();
        in_valid = 1'b0;
        repeat (19) step();
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mul_abort: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        else passed++;
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        total++;
        if (bad != 0) $display("FAIL mul_abort_no_result: got %0d valid cycles want 0", bad);
        else passed++;
    endtask
`else
    task automatic test_mul();
        res_t exp;
        out_ready = 1'b1;
        drive(1'b1, MUL_, 64'd3, 64'd5);
        step();
        drive(1'b0, AND_, 64'h0, 64'h0);
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL mul_off_ready: got %b want 1", in_ready);
        else passed++;
        exp = res_t'{z: 64'h0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b1};
        total++;
        if (out_valid !== 1'b1 || obs !== exp) $display("FAIL mul_off: got v=%b %h want v=1 %h", out_valid, obs, exp);
        else passed++;
        step();
    endtask
`endif

    task automatic test_random();
        res_t q[$];
        res_t exp;
        logic [3:0] op;
        logic [63:0] x, y;
        logic fire_in, fire_out;
        int r, guard;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            case (r % 10)
                0: op = AND_;  1: op = OR_;  2: op = ADD_; 3: op = XOR_;
                4: op = LSL_;  5: op = LSR_; 6: op = SUB_; 7: op = PASS_;
                8: op = ADD_;
                default: op = (r == 19) ? MUL_ : ((r == 9) ? 4'($urandom_range(9, 15)) : SUB_);
            endcase
            x = ($urandom_range(0, 7) == 0) ? 64'h8000_0000_0000_0000 : {$urandom(), $urandom()};
            y = ($urandom_range(0, 7) == 0) ? x : {$urandom(), $urandom()};
            drive($urandom_range(0, 3) != 0, op, x, y);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                total++;
                if (q.size() == 0) $display("FAIL rand_spurious[%0d]: got %h want no result", n, obs);
                else begin
                    exp = q.pop_front();
                    if (obs !== exp) $display("FAIL rand_result[%0d]: got %h want %h", n, obs, exp);
                    else passed++;
                end
            end
            if (fire_in) q.push_back(model(op, x, y));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            #1;
            if (out_valid) begin
                exp = q.pop_front();
                total++;
                if (obs !== exp) $display("FAIL rand_drain: got %h want %h", obs, exp);
                else passed++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (q.size() != 0) $display("FAIL rand_drain_timeout: got %0d pending want 0", q.size());
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_mul();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
